// File: rtl/pipeline_lane_dispatch.sv
// pipeline_lane_dispatch
// Dispatches a single stream of triangles round-robin across NUM_LANES math
// lanes. Each lane has a one-entry output register and an in-flight credit
// counter that is returned by lane_done. A triangle flagged s_last closes the
// frame: intake stops until every lane has drained, then frame_done pulses.

module pipeline_lane_dispatch #(
    parameter int NUM_LANES    = 2,
    parameter int DATA_WIDTH   = 256,
    parameter int META_WIDTH   = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                             clk,
    input  logic                             rstn,

    // Upstream triangle stream
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic [META_WIDTH-1:0]            s_metadata,
    input  logic                             s_last,

    // Per-lane output registers
    output logic [NUM_LANES-1:0]             m_valid,
    input  logic [NUM_LANES-1:0]             m_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  m_data,
    output logic [NUM_LANES*META_WIDTH-1:0]  m_metadata,

    // Completion feedback and status
    input  logic [NUM_LANES-1:0]             lane_done,
    output logic                             frame_done,
    output logic                             busy,
    output logic                             err_underflow
);

    localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [CNT_W-1:0]  CREDIT_LIMIT = CNT_W'(MAX_INFLIGHT);
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(NUM_LANES - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                state;
    state_t                state_nxt;

    logic [LANE_W-1:0]     last_grant;
    logic [LANE_W-1:0]     grant;
    logic                  grant_found;
    logic                  handshake;
    logic                  all_idle;

    logic [NUM_LANES-1:0]  eligible;
    logic [NUM_LANES-1:0]  load;
    logic [NUM_LANES-1:0]  lane_busy;
    logic [NUM_LANES-1:0]  underflow_hit;

    logic [CNT_W-1:0]      inflight [NUM_LANES];
    logic [DATA_WIDTH-1:0] data_q   [NUM_LANES];
    logic [META_WIDTH-1:0] meta_q   [NUM_LANES];

    // Lane index reached by stepping 'offset+1' lanes past 'base', wrapping.
    function automatic logic [LANE_W-1:0] lane_after(input logic [LANE_W-1:0] base,
                                                     input int                offset);
        int sum;
        sum = int'(base) + 1 + offset;
        return LANE_W'(sum % NUM_LANES);
    endfunction

    // ------------------------------------------------------------------
    // Per-lane combinational status
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        // A lane can take a triangle when its register is free (or being
        // taken this cycle) and it still has a credit left.
        assign eligible[i]      = (!m_valid[i] || m_ready[i]) && (inflight[i] < CREDIT_LIMIT);
        assign load[i]          = handshake && (grant == LANE_W'(i));
        assign lane_busy[i]     = m_valid[i] || (inflight[i] != '0);
        assign underflow_hit[i] = lane_done[i] && (inflight[i] == '0);

        assign m_data[i*DATA_WIDTH +: DATA_WIDTH]     = data_q[i];
        assign m_metadata[i*META_WIDTH +: META_WIDTH] = meta_q[i];
    end

    assign all_idle  = ~|lane_busy;
    assign handshake = s_valid && s_ready;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    // Pick the first eligible lane at or after last_grant+1; scanning offsets
    // from the far end down lets the nearest candidate win.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first, otherwise paths that skip the assignment infer a latch.
        grant       = '0;
        grant_found = 1'b0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (eligible[lane_after(last_grant, k)]) begin
                grant       = lane_after(last_grant, k);
                grant_found = 1'b1;
            end
        end
    end

    // Remember the lane that took the last triangle so the next search starts after it.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn) begin
            last_grant <= LAST_LANE;
        end else if (handshake) begin
            last_grant <= grant;
        end
    end

    // ------------------------------------------------------------------
    // Lane output registers
    // ------------------------------------------------------------------
    // Valid bit: set on load, cleared when the lane takes it without a reload.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (load[i]) begin
                    m_valid[i] <= 1'b1;
                end else if (m_ready[i]) begin
                    m_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Payload capture; content is only meaningful while the matching valid is high.
    always_ff @(posedge clk) begin
        // NOTE: the wide payload registers are deliberately left without reset;
        // m_valid alone qualifies them, so a reset would only cost routing.
        for (int i = 0; i < NUM_LANES; i++) begin
            if (load[i]) begin
                data_q[i] <= s_data;
                meta_q[i] <= s_metadata;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight credit counters
    // ------------------------------------------------------------------
    // Count up on a grant, down on lane_done; simultaneous events cancel and
    // a done against an empty counter is absorbed (and flagged below).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                inflight[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (load[i] && !lane_done[i]) begin
                    inflight[i] <= inflight[i] + 1'b1;
                end else if (!load[i] && lane_done[i] && (inflight[i] != '0)) begin
                    inflight[i] <= inflight[i] - 1'b1;
                end
            end
        end
    end

    // Sticky underflow flag: a lane reported completion with nothing in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_underflow <= 1'b0;
        end else if (|underflow_hit) begin
            err_underflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: the last triangle of a frame closes intake; a fully idle
    // block in DRAIN reopens it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (handshake && s_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (all_idle) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Outputs: intake only while running, frame_done on the exit from DRAIN.
    always_comb begin
        s_ready    = (state == ST_RUN) && grant_found;
        frame_done = (state == ST_DRAIN) && all_idle;
        busy       = (state != ST_RUN) || !all_idle;
    end

endmodule

// File: tb/tb_pipeline_lane_dispatch.sv
// Testbench for pipeline_lane_dispatch: directed scenarios driven against a
// transaction-level model of the dispatcher (credits, one slot per lane,
// round-robin order, frame drain), compared every cycle, plus literal checks
// on grant order and key handshake points.

module tb_pipeline_lane_dispatch;

    localparam int NL = 2;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int MI = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [MW-1:0]     s_metadata;
    logic              s_last;
    logic [NL-1:0]     m_valid;
    logic [NL-1:0]     m_ready;
    logic [NL*DW-1:0]  m_data;
    logic [NL*MW-1:0]  m_metadata;
    logic [NL-1:0]     lane_done;
    logic              frame_done;
    logic              busy;
    logic              err_underflow;

    always #5 clk = ~clk;

    pipeline_lane_dispatch #(
        .NUM_LANES   (NL),
        .DATA_WIDTH  (DW),
        .META_WIDTH  (MW),
        .MAX_INFLIGHT(MI)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_metadata   (s_metadata),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_metadata   (m_metadata),
        .lane_done    (lane_done),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_underflow(err_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what each lane holds, how many triangles each lane
    // owes, who was served last, whether a frame is closing.
    // ------------------------------------------------------------------
    int            mdl_cnt [NL];
    bit            mdl_mv  [NL];
    logic [DW-1:0] mdl_md  [NL];
    logic [MW-1:0] mdl_mm  [NL];
    int            mdl_last;
    bit            mdl_drain;
    bit            mdl_err;
    int            grant_log [$];

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            mdl_cnt[l] = 0;
            mdl_mv[l]  = 0;
        end
        mdl_last  = NL - 1;
        mdl_drain = 0;
        mdl_err   = 0;
    endtask

    task automatic mdl_eval(output bit rdy, output int g, output bit fd, output bit bz);
        bit idle;
        g    = -1;
        idle = 1;
        for (int k = 0; k < NL; k++) begin
            int l;
            l = (mdl_last + 1 + k) % NL;
            if (g < 0 && (!mdl_mv[l] || m_ready[l]) && mdl_cnt[l] < MI) g = l;
        end
        for (int l = 0; l < NL; l++) begin
            if (mdl_mv[l] || mdl_cnt[l] != 0) idle = 0;
        end
        rdy = !mdl_drain && (g >= 0);
        fd  = mdl_drain && idle;
        bz  = mdl_drain || !idle;
    endtask

    task automatic model_step();
        bit rdy, fd, bz, hs, inc;
        int g;
        if (!rstn) begin
            model_reset();
        end else begin
            mdl_eval(rdy, g, fd, bz);
            hs = s_valid && rdy;
            for (int l = 0; l < NL; l++) begin
                inc = hs && (g == l);
                if (lane_done[l] && mdl_cnt[l] == 0) mdl_err = 1;
                if (inc && !lane_done[l]) mdl_cnt[l]++;
                else if (!inc && lane_done[l] && mdl_cnt[l] > 0) mdl_cnt[l]--;
                if (inc) begin
                    mdl_mv[l] = 1;
                    mdl_md[l] = s_data;
                    mdl_mm[l] = s_metadata;
                end else if (mdl_mv[l] && m_ready[l]) begin
                    mdl_mv[l] = 0;
                end
            end
            if (hs) begin
                grant_log.push_back(g);
                mdl_last = g;
            end
            if (fd) mdl_drain = 0;
            else if (hs && s_last) mdl_drain = 1;
        end
    endtask

    task automatic compare();
        bit rdy, fd, bz;
        int g;
        mdl_eval(rdy, g, fd, bz);
        check("s_ready", s_ready, rdy);
        check("frame_done", frame_done, fd);
        check("busy", busy, bz);
        check("err_underflow", err_underflow, mdl_err);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("m_valid[%0d]", l), m_valid[l], mdl_mv[l]);
            if (mdl_mv[l]) begin
                check($sformatf("m_data[%0d]", l), m_data[l*DW +: DW], mdl_md[l]);
                check($sformatf("m_metadata[%0d]", l), m_metadata[l*MW +: MW], mdl_mm[l]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle driver: compare at negedge, advance model at posedge, then
    // update the lane_done responder (done returned 3 cycles after take).
    // ------------------------------------------------------------------
    logic [NL-1:0] dly0, dly1, dly2, manual_done, hs_m;
    bit            auto_en;
    bit            last_acc;
    int            fd_total;

    task automatic cycle();
        @(negedge clk);
        if (rstn) compare();
        last_acc = s_valid && s_ready;
        if (frame_done) fd_total++;
        hs_m = m_valid & m_ready;
        @(posedge clk);
        model_step();
        #1;
        dly2      = dly1;
        dly1      = dly0;
        dly0      = auto_en ? hs_m : '0;
        lane_done = dly2 | manual_done;
    endtask

    task automatic drive_done(input logic [NL-1:0] v);
        manual_done = v;
        lane_done   = dly2 | manual_done;
    endtask

    task automatic send(input int k, input bit last);
        int tries;
        tries      = 0;
        s_valid    = 1'b1;
        s_data     = 32'hA000_0000 + 32'(k);
        s_metadata = MW'(k);
        s_last     = last;
        do begin
            cycle();
            tries++;
        end while (!last_acc && tries < 30);
        check($sformatf("accept triangle %0d", k), last_acc, 1'b1);
        s_last = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        check("drain to idle", busy, 1'b0);
    endtask

    task automatic check_grants(input string tag, input int exp[$]);
        check({tag, " grant count"}, grant_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++) begin
            check($sformatf("%s grant %0d", tag, i), grant_log[i], exp[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e[$];
        int fd0;
        bit seen;

        s_valid = 0; s_data = '0; s_metadata = '0; s_last = 0;
        m_ready = 2'b11; lane_done = '0; manual_done = '0;
        dly0 = '0; dly1 = '0; dly2 = '0; hs_m = '0;
        auto_en = 0; last_acc = 0; fd_total = 0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        model_reset();
        #1;
        check("reset m_valid", m_valid, 2'b00);
        check("reset busy", busy, 1'b0);
        check("reset err_underflow", err_underflow, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        repeat (3) cycle();
        rstn = 1'b1;
        cycle();
        check("s_ready after reset", s_ready, 1'b1);

        // Back-to-back stream with automatic completions: lanes alternate.
        auto_en = 1;
        grant_log.delete();
        send(0, 0);
        check("first m_valid", m_valid, 2'b01);
        check("first m_data", m_data[DW-1:0], 32'hA000_0000);
        for (int k = 1; k < 6; k++) send(k, 0);
        s_valid = 0;
        wait_idle(40);
        e = '{0, 1, 0, 1, 0, 1};
        check_grants("rr", e);

        // Credit limit: no completions, four triangles fill both lanes.
        auto_en = 0;
        grant_log.delete();
        for (int k = 10; k < 14; k++) send(k, 0);
        s_valid = 1; s_data = 32'hA000_000E; s_metadata = 8'd14;
        cycle();
        cycle();
        check("credit stall no accept", last_acc, 1'b0);
        check("credit stall s_ready", s_ready, 1'b0);
        drive_done(2'b10);
        cycle();
        drive_done(2'b00);
        check("credit returned s_ready", s_ready, 1'b1);
        cycle();
        check("retry accepted", last_acc, 1'b1);
        s_valid = 0;
        e = '{0, 1, 0, 1, 1};
        check_grants("credit", e);
        drive_done(2'b11);
        cycle();
        cycle();
        drive_done(2'b00);
        wait_idle(10);

        // Frame end: third triangle is last; exactly one frame_done.
        auto_en = 1;
        grant_log.delete();
        send(20, 0);
        send(21, 0);
        send(22, 1);
        s_valid = 0;
        check("drain s_ready", s_ready, 1'b0);
        fd0  = fd_total;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            cycle();
            if (fd_total != fd0) begin
                seen = 1;
                cycle();
                check("s_ready after frame_done", s_ready, 1'b1);
            end
        end
        repeat (3) cycle();
        check("frame_done pulse count", fd_total - fd0, 1);
        e = '{0, 1, 0};
        check_grants("frame", e);

        // Same-cycle grant and done on lane 0, then underflow on lane 1.
        auto_en = 0;
        grant_log.delete();
        send(30, 0);
        send(31, 0);
        send(32, 0);
        drive_done(2'b01);
        send(33, 0);
        drive_done(2'b00);
        check("counter unchanged s_ready", s_ready, 1'b1);
        send(34, 0);
        s_valid = 0;
        check("both lanes full", s_ready, 1'b0);
        e = '{1, 0, 1, 0, 0};
        check_grants("cancel", e);
        drive_done(2'b11);
        cycle();
        cycle();
        drive_done(2'b00);
        check("no underflow yet", err_underflow, 1'b0);
        drive_done(2'b10);
        cycle();
        drive_done(2'b00);
        check("underflow set", err_underflow, 1'b1);
        repeat (3) cycle();
        check("underflow sticky", err_underflow, 1'b1);

        // Lane 0 back-pressured: its payload holds, traffic goes to lane 1.
        auto_en = 1;
        m_ready = 2'b10;
        grant_log.delete();
        send(40, 0);
        send(41, 0);
        for (int k = 42; k < 45; k++) begin
            send(k, 0);
            check("held m_valid[0]", m_valid[0], 1'b1);
            check("held m_data[0]", m_data[DW-1:0], 32'hA000_0029);
        end
        s_valid = 0;
        e = '{1, 0, 1, 1, 1};
        check_grants("stall", e);
        m_ready = 2'b11;
        wait_idle(40);

        // Reset while draining: no frame_done, everything back to reset.
        auto_en = 0;
        send(50, 1);
        s_valid = 0;
        cycle();
        check("drain before reset", s_ready, 1'b0);
        check("busy before reset", busy, 1'b1);
        fd0 = fd_total;
        rstn = 1'b0;
        model_reset();
        dly0 = '0; dly1 = '0; dly2 = '0;
        drive_done(2'b00);
        #1;
        check("mid-frame reset m_valid", m_valid, 2'b00);
        check("mid-frame reset busy", busy, 1'b0);
        check("mid-frame reset err", err_underflow, 1'b0);
        check("mid-frame reset frame_done", frame_done, 1'b0);
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();
        check("s_ready after mid-frame reset", s_ready, 1'b1);
        repeat (4) cycle();
        check("no frame_done across reset", fd_total - fd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_lane_dispatch.md
PIPELINE_LANE_DISPATCH -- requirements
Module: pipeline_lane_dispatch

Interface
REQ-001 Parameter NUM_LANES, default 2, number of parallel math lanes; legal range 1..8.
REQ-002 Parameter DATA_WIDTH, default 256, triangle payload width in bits.
REQ-003 Parameter META_WIDTH, default 8, triangle metadata width in bits.
REQ-004 Parameter MAX_INFLIGHT, default 4, maximum unfinished triangles per lane; legal range 1..15.
REQ-005 clk  input  1  system clock; the only clock; all logic on rising edge.
REQ-006 rstn  input  1  reset; asynchronous assert, active-low.
REQ-007 s_valid  input  1  upstream triangle valid.
REQ-008 s_ready  output  1  block accepts the upstream triangle this cycle.
REQ-009 s_data  input  DATA_WIDTH  triangle payload.
REQ-010 s_metadata  input  META_WIDTH  triangle metadata.
REQ-011 s_last  input  1  triangle is the last of its frame.
REQ-012 m_valid  output  NUM_LANES  per-lane output valid.
REQ-013 m_ready  input  NUM_LANES  per-lane output ready.
REQ-014 m_data  output  NUM_LANES*DATA_WIDTH  per-lane payload; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 m_metadata  output  NUM_LANES*META_WIDTH  per-lane metadata, packed as for m_data.
REQ-016 lane_done  input  NUM_LANES  one-cycle pulse per lane; that lane finished one triangle.
REQ-017 frame_done  output  1  one-cycle pulse; the frame is fully drained.
REQ-018 busy  output  1  high when any lane is occupied or the FSM is not in RUN.
REQ-019 err_underflow  output  1  sticky; lane_done arrived while that lane's counter was zero.

Function
REQ-020 Each lane has one output register (valid, data, metadata) and a $clog2(MAX_INFLIGHT+1)-bit in-flight counter.
REQ-021 Lane i is eligible when its output register is empty, or emptying this cycle (m_valid[i]&&m_ready[i]), and its counter < MAX_INFLIGHT.
REQ-022 The FSM has states RUN and DRAIN.
REQ-023 s_ready is combinational: high iff state==RUN and at least one lane is eligible; s_ready does not depend on s_valid.
REQ-024 Round-robin grant: the lowest-index eligible lane at or after (last_grant+1) mod NUM_LANES; last_grant resets to NUM_LANES-1, so lane 0 is granted first.
REQ-025 On handshake (s_valid&&s_ready) at cycle N, the granted lane register loads s_data/s_metadata and m_valid is high from N+1; latency is 1 cycle.
REQ-026 m_valid[i] holds with stable data until m_ready[i]; it clears on handshake unless the lane reloads in the same cycle.
REQ-027 A lane's counter increments on the input handshake granted to it and decrements on lane_done[i]; when both occur in the same cycle it is unchanged.
REQ-028 lane_done[i] with counter==0 leaves the counter at 0 and sets err_underflow.
REQ-029 An input handshake with s_last=1 moves the FSM RUN->DRAIN in the next cycle.
REQ-030 In DRAIN, s_ready=0.
REQ-031 In DRAIN, when all counters==0 and all m_valid==0, frame_done pulses for exactly one cycle and the FSM returns to RUN in the same cycle.
REQ-032 A lane completes its in-flight work with lane_done only after taking the triangle (m handshake); the block does not check this ordering.
REQ-033 With NUM_LANES=1, behaviour reduces to a single registered stage with credit limit MAX_INFLIGHT.

Reset
REQ-034 On rstn low: state=RUN, all m_valid=0, counters=0, last_grant=NUM_LANES-1, frame_done=0, err_underflow=0, busy=0; s_ready is high from the first cycle after release.
REQ-035 Reset asserted mid-frame discards held triangles and counters without emitting frame_done.
REQ-036 m_data and m_metadata are not reset and are don't-care while m_valid=0.

Verification
REQ-037 NUM_LANES=2, m_ready=11, lane_done returned 3 cycles after each m handshake, 6 triangles sent back to back -> lanes granted 0,1,0,1,0,1; each m_valid rises 1 cycle after its s handshake.
REQ-038 MAX_INFLIGHT=2, lane_done held 0, m_ready=11 -> 4 triangles accepted, then s_ready=0; one lane_done[1] pulse -> s_ready=1 and the next triangle goes to lane 1.
REQ-039 Third triangle sent with s_last=1 -> s_ready=0 until all lanes are done; frame_done pulses exactly once; s_ready=1 in the following cycle.
REQ-040 lane_done[0] and a grant to lane 0 in the same cycle -> lane 0 counter unchanged; lane_done[1] pulsed with counter 0 -> err_underflow=1 and stays 1 until reset.
REQ-041 m_ready[0]=0 while lane 0 holds a triangle -> m_data lane 0 stays stable; new triangles go to lane 1 only.
REQ-042 rstn pulsed low while in DRAIN -> all outputs at reset values, no frame_done pulse, s_ready=1 one cycle after release.
